// File: rtl/alu_pkg.sv
// Shared types for the ALU operation sequencer: opcodes, FSM states, legality check.
package alu_pkg;

  localparam int unsigned CODE_W   = 4;
  localparam int unsigned OPSEL_W  = 3;
  localparam int unsigned FLAGS_W  = 4;
  localparam int unsigned SETTLE_W = 4;

  typedef enum logic [CODE_W-1:0] {
    OP_ADD    = 4'h0,
    OP_SUBWB  = 4'h1,
    OP_MOV    = 4'h2,
    OP_SUB    = 4'h3,
    OP_INC    = 4'h4,
    OP_DEC    = 4'h5,
    OP_ADDINC = 4'h6,
    OP_AND    = 4'h8,
    OP_OR     = 4'h9,
    OP_XOR    = 4'hA,
    OP_NOT    = 4'hB,
    OP_SHL    = 4'hD
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [CODE_W-1:0] code);
    case (code)
      OP_ADD, OP_SUBWB, OP_MOV, OP_SUB, OP_INC, OP_DEC, OP_ADDINC,
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL: is_legal_op = 1'b1;
      default:                                is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_8bit.sv
// External 8-bit ALU driven by the sequencer: mode 0 arithmetic, mode 1 logic/shift.
module alu_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] opsel,
  input  logic       mode,
  output logic [7:0] result,
  output logic       c,
  output logic       z,
  output logic       o,
  output logic       s
);

  localparam int unsigned W = 8;

  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  logic [W:0]   sum;

  // Every arithmetic op is x + y + cin so carry/overflow share one formula.
  always_comb begin
    x      = a;
    y      = '0;
    cin    = 1'b0;
    sum    = '0;
    result = '0;
    c      = 1'b0;
    o      = 1'b0;
    if (!mode) begin
      case (opsel)
        3'd0: y = b;
        3'd1: y = ~b;
        3'd3: begin y = ~b; cin = 1'b1; end
        3'd4: cin = 1'b1;
        3'd5: y = '1;
        3'd6: begin y = b; cin = 1'b1; end
        default: ;
      endcase
      sum    = {1'b0, x} + {1'b0, y} + (W+1)'(cin);
      result = sum[W-1:0];
      c      = sum[W];
      o      = (x[W-1] == y[W-1]) && (result[W-1] != x[W-1]);
    end else begin
      case (opsel)
        3'd0: result = a & b;
        3'd1: result = a | b;
        3'd2: result = a ^ b;
        3'd3: result = ~a;
        3'd5: begin result = {a[W-2:0], 1'b0}; c = a[W-1]; end
        default: result = '0;
      endcase
    end
  end

  assign z = (result == '0);
  assign s = result[W-1];

endmodule

// File: rtl/alu_settle_counter.sv
// Settle-time down counter: load, decrement in DRIVE, flag the final settle cycle.
module alu_settle_counter
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                dec,
  output logic                last_c
);

  logic [SETTLE_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - SETTLE_W'(1);
    end
  end

  // High on the cycle whose edge takes the count to zero.
  assign last_c = (count == SETTLE_W'(1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one command at a time through an external ALU and returns its result.
// Optional statistics counters are enabled with `define ALU_SEQ_STATS_EN.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DWIDTH-1:0]   cmd_op1,
  input  logic [DWIDTH-1:0]   cmd_op2,
  input  logic [CODE_W-1:0]   cmd_code,
  output logic [DWIDTH-1:0]   alu_op1,
  output logic [DWIDTH-1:0]   alu_op2,
  output logic [OPSEL_W-1:0]  alu_opsel,
  output logic                alu_mode,
  input  logic [DWIDTH-1:0]   alu_result,
  input  logic                alu_c,
  input  logic                alu_z,
  input  logic                alu_o,
  input  logic                alu_s,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DWIDTH-1:0]   rsp_result,
  output logic [FLAGS_W-1:0]  rsp_flags,
`ifdef ALU_SEQ_STATS_EN
  output logic [15:0]         stat_ops,
  output logic [15:0]         stat_errs,
`endif
  output logic                rsp_err
);

  state_e state;
  logic   load_c;
  logic   dec_c;
  logic   last_c;

  assign load_c = (state == ST_IDLE) && cmd_valid && is_legal_op(cmd_code);
  assign dec_c  = (state == ST_DRIVE);

  alu_settle_counter u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .load_val (SETTLE_W'(SETTLE)),
    .dec      (dec_c),
    .last_c   (last_c)
  );

  // Control FSM; alu_* only change on a legal accept so they hold in IDLE/RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_opsel  <= '0;
      alu_mode   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            if (is_legal_op(cmd_code)) begin
              alu_op1   <= cmd_op1;
              alu_op2   <= cmd_op2;
              alu_opsel <= cmd_code[OPSEL_W-1:0];
              alu_mode  <= cmd_code[CODE_W-1];
              state     <= ST_DRIVE;
            end else begin
              rsp_err    <= 1'b1;
              rsp_result <= '0;
              rsp_flags  <= '0;
              rsp_valid  <= 1'b1;
              state      <= ST_RESP;
            end
          end
        end
        ST_DRIVE: begin
          if (last_c) begin
            rsp_result <= alu_result;
            rsp_flags  <= {alu_c, alu_z, alu_o, alu_s};
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else if (rsp_valid && rsp_ready) begin
      stat_ops <= stat_ops + 16'(1);
      if (rsp_err) begin
        stat_errs <= stat_errs + 16'(1);
      end
    end
  end
`endif

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter DWIDTH, default 8, operand/result width in bits.
REQ-002 Parameter SETTLE, default 1, cycles (1..15) the ALU inputs are held before capture.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  sequencer can accept a command.
REQ-007 cmd_op1, cmd_op2  input  DWIDTH  command operands.
REQ-008 cmd_code  input  4  opcode {mode, opsel[2:0]}.
REQ-009 alu_op1, alu_op2  output  DWIDTH  operands driven to the ALU.
REQ-010 alu_opsel  output  3  ALU opsel (cmd_code[2:0]).
REQ-011 alu_mode  output  1  ALU mode (cmd_code[3]).
REQ-012 alu_result  input  DWIDTH  ALU result.
REQ-013 alu_c, alu_z, alu_o, alu_s  input  1 each  ALU carry/zero/overflow/sign flags.
REQ-014 rsp_valid  output  1  response present.
REQ-015 rsp_ready  input  1  consumer accepts response.
REQ-016 rsp_result  output  DWIDTH  captured result.
REQ-017 rsp_flags  output  4  captured {c,z,o,s}.
REQ-018 rsp_err  output  1  command was an illegal opcode.

Function
REQ-019 Legal opcodes: 0 add, 1 subwb, 2 mov, 3 sub, 4 inc, 5 dec, 6 addinc, 8 and, 9 or, A xor, B not, D shl; 7, C, E, F illegal.
REQ-020 FSM states IDLE, DRIVE, RESP; cmd_ready = 1 only in IDLE.
REQ-021 IDLE: cmd_valid=1 with legal opcode registers operands/code onto alu_* outputs, loads settle counter with SETTLE, moves to DRIVE.
REQ-022 IDLE: cmd_valid=1 with illegal opcode does not change alu_* outputs, sets rsp_err=1, rsp_result=0, rsp_flags=0, moves directly to RESP.
REQ-023 DRIVE: counter decrements each cycle; alu_* outputs held stable; when counter reaches 0, alu_result and flags are registered into rsp_* with rsp_err=0 and FSM moves to RESP.
REQ-024 Latency legal command: handshake cycle to rsp_valid rising = SETTLE+1 cycles; illegal command: 1 cycle.
REQ-025 RESP: rsp_valid=1; rsp_* stable until rsp_valid&&rsp_ready, then FSM returns to IDLE the next edge.
REQ-026 One command outstanding; no new command accepted in DRIVE or RESP, even if rsp_ready is already 1 (no same-cycle accept/return bypass).
REQ-027 alu_* outputs retain last driven values in IDLE and RESP (no glitching to zero).
REQ-028 Widths pass through unchanged; no arithmetic performed inside the block.

Reset
REQ-029 rst=1 forces IDLE, settle counter 0, cmd_ready=1 after release, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0, alu_op1=alu_op2=0, alu_opsel=0, alu_mode=0.
REQ-030 Reset mid-DRIVE or mid-RESP discards the command; no response is produced.

Configuration
REQ-031 Macro ALU_SEQ_STATS_EN: when defined, adds outputs stat_ops (16-bit, count of completed responses, wraps 0xFFFF->0) and stat_errs (16-bit, count of illegal commands, wraps), both reset to 0 and incremented on the response handshake.
REQ-032 Without ALU_SEQ_STATS_EN, those ports and counters do not exist; all other behaviour identical.

Structure
REQ-033 Shared package alu_pkg holds the opcode enum (values per REQ-019), FSM state enum, and an is_legal_op function.
REQ-034 One sub-module, alu_settle_counter (load/decrement/zero flag), is natural; the ALU itself stays external.

Verification
REQ-035 Bench instantiates alu_op_sequencer with alu_8bit; legal command op1=0x6E, op2=0x1B, code=0 -> rsp_result=0x89, flags c=0,z=0,o=1,s=1, rsp_valid at cycle SETTLE+1.
REQ-036 op1=0x00, op2=0x00, code=0 -> rsp_result=0x00, z=1; code=8 (and) same operands -> z=1, rsp_err=0.
REQ-037 code=7 with op1=0x6E -> rsp_err=1, rsp_result=0, 1-cycle latency, alu_* outputs unchanged from previous command.
REQ-038 rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, cmd_ready=0, a pending cmd_valid is not accepted until after handshake.
REQ-039 Assert rst during DRIVE -> next cycle rsp_valid=0, all outputs at reset values, no response issued after release.
REQ-040 With ALU_SEQ_STATS_EN: 3 legal + 1 illegal command -> stat_ops=4, stat_errs=1; preload via 65536 ops -> stat_ops wraps to 0.
